mdu_iter: RTL and testbench

Parametrised multiply/divide unit for the CPU execute stage, successor to the fixed 32-bit HI/LO unit. Supports signed/unsigned multiply, multiply-accumulate and subtract (MADD/MSUB), and divide through an iterative restoring divider. It also supports MTHI/MTLO writes and a flush that aborts an in-flight operation on exception. The pipeline stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_div_core.sv | 69 ++++++
 rtl/mdu_iter.sv | 175 +++++++++++++++++
 tb/tb_mdu_iter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   md_op_e  - 4-bit operation codes presented on md_op
//   state_e  - control FSM states
//   CNT_W    - width of the multiply latency counter (MUL_LAT up to 15)
//   is_mul / is_div / is_signed - op classification helpers
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int CNT_W = 4;

  // Plain multiply and both accumulate flavours share the MUL state.
  function automatic logic is_mul(input md_op_e op);
    return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic is_signed(input md_op_e op);
    return op inside {MULT, DIV, MADD, MSUB};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per clock.
//   clk, reset     - clock, synchronous active-high reset
//   load           - capture dividend/divisor and start WIDTH iterations
//   kill           - abandon the current division
//   dividend       - dividend magnitude
//   divisor        - divisor magnitude
//   quotient       - quotient (valid the cycle after done)
//   remainder      - remainder (valid the cycle after done)
//   done           - high during the cycle whose clock edge forms the last
//                    quotient bit, so the caller can step on that same edge
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB. One extra
  // bit on the trial subtraction acts as the borrow / "restore" flag.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (cnt_q != '0) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (cnt_q == CW'(1));

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: HI/LO multiply/divide unit for the execute stage.
//   clk, reset - clock, synchronous active-high reset
//   start      - issue md_op this cycle (ignored while busy)
//   flush      - abort any in-flight operation; wins over start
//   md_op      - operation code (mdu_pkg::md_op_e)
//   a, b       - rs / rt operands, latched at issue
//   busy       - registered; high while an operation is in flight
//   hi, lo     - architectural HI / LO registers
// Multiply/MAC takes MUL_LAT cycles; divide takes WIDTH iterations plus one
// sign-fix cycle. MTHI/MTLO complete in one cycle without asserting busy.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_op_e             op_in;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] snap_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] mul_res_d;
  logic [WIDTH-1:0]   div_a_mag;
  logic [WIDTH-1:0]   div_b_mag;
  logic               div_load;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               div_done;
  logic [WIDTH-1:0]   div_hi_d;
  logic [WIDTH-1:0]   div_lo_d;

  assign op_in = md_op_e'(md_op);

  // Multiply datapath on the latched operands. Extending to 2*WIDTH before
  // the multiply makes the truncated product correct for signed ops too.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mul_res_d = '0;
    a_ext = is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    unique case (op_q)
      MADD, MADDU: mul_res_d = snap_q + a_ext * b_ext;
      MSUB, MSUBU: mul_res_d = snap_q - a_ext * b_ext;
      default:     mul_res_d = a_ext * b_ext;
    endcase
  end

  // The divider is loaded straight from the issue-cycle inputs so its first
  // iteration lines up with the first busy cycle.
  always_comb begin
    div_a_mag = (op_in == DIV && a[WIDTH-1]) ? -a : a;
    div_b_mag = (op_in == DIV && b[WIDTH-1]) ? -b : b;
    div_load  = start && !flush && (state_q == ST_IDLE) && is_div(op_in);
  end

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .kill     (flush),
    .dividend (div_a_mag),
    .divisor  (div_b_mag),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  // Sign fix-up: quotient negative when operand signs differ, remainder takes
  // the dividend's sign. MIN / -1 falls out naturally: the magnitude quotient
  // is 2^(WIDTH-1) and negating it yields MIN again, with remainder 0.
  always_comb begin
    div_lo_d = div_quo;
    div_hi_d = div_rem;
    if (b_q == '0) begin
      div_lo_d = '1;
      div_hi_d = a_q;
    end else if (op_q == DIV) begin
      if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) div_lo_d = -div_quo;
      if (a_q[WIDTH-1])                div_hi_d = -div_rem;
    end
  end

  // NOTE: sequential state is assigned with <= only, so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      snap_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_in;
            a_q    <= a;
            b_q    <= b;
            snap_q <= {hi_q, lo_q};
            if (is_mul(op_in)) begin
              state_q <= ST_MUL;
              cnt_q   <= CNT_W'(MUL_LAT - 1);
              busy_q  <= 1'b1;
            end else if (is_div(op_in)) begin
              state_q <= ST_DIV;
              busy_q  <= 1'b1;
            end else if (op_in == MTHI) begin
              hi_q <= a;
            end else if (op_in == MTLO) begin
              lo_q <= a;
            end
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_res_d;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_done) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= div_hi_d;
          lo_q    <= div_lo_d;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter. A 32-bit
// instance (MUL_LAT=5) is checked against an arithmetic reference model;
// a 16-bit instance (MUL_LAT=1) covers the short-latency configuration.
module tb_mdu_iter;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        s_start;
  logic [3:0]  s_md_op;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        s_busy;
  logic [15:0] s_hi;
  logic [15:0] s_lo;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .flush(flush),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(1)) dut16 (
    .clk  (clk),
    .reset(reset),
    .start(s_start),
    .flush(1'b0),
    .md_op(s_md_op),
    .a    (s_a),
    .b    (s_b),
    .busy (s_busy),
    .hi   (s_hi),
    .lo   (s_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the architectural meaning of each op in plain arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] hl);
    longint      sp;
    logic [63:0] up;
    int          sx;
    int          sy;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'd0, x} * {32'd0, y};
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return hl + sp;
      OP_MADDU: return hl + up;
      OP_MSUB:  return hl - sp;
      OP_MSUBU: return hl - up;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      OP_MTHI:  return {x, hl[31:0]};
      OP_MTLO:  return {hl[63:32], x};
      default:  return hl;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 5;
      OP_DIV, OP_DIVU: return 33;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble the inputs afterwards, count busy cycles and
  // compare latency and final HI/LO with the model.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    int          n;
    logic [63:0] exp;
    exp = model(op, x, y, {m_hi, m_lo});
    @(negedge clk);
    md_op = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; md_op = 4'($urandom_range(0, 15));
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " busy cycles"}, 64'(n), 64'(exp_lat(op)));
    check({tag, " hi:lo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       input string tag);
    int          n;
    logic [31:0] exp;
    if (op == OP_MULT) exp = 32'(int'($signed(x)) * int'($signed(y)));
    else               exp = {16'd0, x} * {16'd0, y};
    @(negedge clk);
    s_md_op = op; s_a = x; s_b = y; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom);
    n = 0;
    while (s_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " busy cycles"}, 64'(n), 64'd1);
    check({tag, " hi:lo"}, 64'({s_hi, s_lo}), 64'(exp));
  endtask

  initial begin
    int          n;
    logic [63:0] held;

    reset = 1'b1; start = 1'b0; flush = 1'b0; md_op = OP_NONE; a = '0; b = '0;
    s_start = 1'b0; s_md_op = OP_NONE; s_a = '0; s_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases with hand-computed expectations.
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult neg");
    check("mult neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div neg");
    check("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, "divu");
    check("divu const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
    run_op(OP_DIVU, 32'h0000_1234, 32'h0000_0000, "divu by zero");
    check("divu by zero const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    check("div overflow const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(OP_MTHI, 32'd0, 32'd0, "mthi zero");
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, "mtlo ones");
    run_op(OP_MADDU, 32'd1, 32'd1, "maddu carry");
    check("maddu carry const", {hi, lo}, 64'h0000_0001_0000_0000);
    run_op(OP_MTHI, 32'd0, 32'd0, "mthi clr");
    run_op(OP_MTLO, 32'd0, 32'd0, "mtlo clr");
    run_op(OP_MSUB, 32'd1, 32'd1, "msub borrow");
    check("msub borrow const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush at busy cycle 10 of a divide: no write, idle next cycle.
    held = {m_hi, m_lo};
    @(negedge clk);
    md_op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("busy before flush", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi:lo", {hi, lo}, held);
    repeat (40) @(posedge clk);
    #1;
    check("flush later busy", 64'(busy), 64'd0);
    check("flush later hi:lo", {hi, lo}, held);

    // Flush together with MTLO: the write is dropped.
    @(negedge clk);
    md_op = OP_MTLO; a = 32'h1234_5678; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush+mtlo hi:lo", {hi, lo}, held);
    check("flush+mtlo busy", 64'(busy), 64'd0);

    // MTHI issued at busy cycle 3 of a MULT is ignored.
    @(negedge clk);
    md_op = OP_MULT; a = 32'd12345; b = 32'hFFFF_FF00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    repeat (2) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    md_op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n++;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mthi while busy cycles", 64'(n - 1), 64'd5);
    {m_hi, m_lo} = model(OP_MULT, 32'd12345, 32'hFFFF_FF00, {m_hi, m_lo});
    check("mthi while busy hi:lo", {hi, lo}, {m_hi, m_lo});

    // Reset in the middle of a MULT.
    @(negedge clk);
    md_op = OP_MULT; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset mid-mult busy", 64'(busy), 64'd0);
    check("reset mid-mult hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    // Randomized ops, including MD_NONE and undefined codes.
    for (int i = 0; i < 120; i++) begin
      run_op(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), $sformatf("rand%0d", i));
    end

    // 16-bit, single-cycle multiply configuration.
    run16(OP_MULT, 16'hFFFE, 16'h0003, "w16 mult neg");
    check("w16 mult neg const", 64'({s_hi, s_lo}), 64'h0000_0000_FFFF_FFFA);
    for (int i = 0; i < 20; i++) begin
      run16(($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU, 16'($urandom), 16'($urandom),
            $sformatf("w16 rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
